// File: rtl/opcode_prefetch_queue_if.sv
// Byte-wide instruction fetch bus between the prefetcher and the MMU.
//   master (prefetcher): drives mem_addr and mem_req, and receives mem_data and mem_busy.
//   slave  (MMU):        receives mem_addr and mem_req, and drives mem_data and mem_busy.
// The MMU raises mem_busy once it has accepted mem_req. When it drops mem_busy again,
// mem_data is valid.
interface opcode_prefetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_req;
  logic [7:0]            mem_data;
  logic                  mem_busy;

  modport master (
    output mem_addr,
    output mem_req,
    input  mem_data,
    input  mem_busy
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    output mem_data,
    output mem_busy
  );
endinterface

// File: rtl/opcode_prefetch_queue.sv
// Sequential opcode prefetcher.
// It fetches OPCODE_BYTES bytes per opcode over the byte-wide MMU port, starting at the
// last redirect address. It assembles each opcode in the configured byte order and queues
// {opcode, address} in a DEPTH-entry FIFO for the decoder.
//
// Ports:
//   clk, reset      single clock; synchronous active-low reset
//   redirect        one-cycle pulse: flush the queue and restart at redirect_ip
//   redirect_ip     new fetch address
//   run             level; 0 holds off new byte accesses (an access already started still finishes)
//   consume         pop the head entry; ignored while opcode_valid is 0
//   opcode_valid    queue non-empty
//   opcode          head opcode
//   opcode_ip       address of the head opcode
//   busy            ~opcode_valid
//   mem             MMU fetch bus (master side); its ADDR_WIDTH must match this module's
module opcode_prefetch_queue #(
  parameter int unsigned OPCODE_BYTES = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter bit          BIG_ENDIAN   = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect,
  input  logic [ADDR_WIDTH-1:0]     redirect_ip,
  input  logic                      run,
  input  logic                      consume,
  output logic                      opcode_valid,
  output logic [8*OPCODE_BYTES-1:0] opcode,
  output logic [ADDR_WIDTH-1:0]     opcode_ip,
  output logic                      busy,
  opcode_prefetch_queue_if.master   mem
);

  localparam int unsigned W    = 8 * OPCODE_BYTES;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned IdxW = (OPCODE_BYTES > 1) ? $clog2(OPCODE_BYTES) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [IdxW-1:0]       byte_idx_q, byte_idx_d;
  logic                  armed_q, armed_d;
  logic                  drop_q, drop_d;
  logic [W-1:0]          asm_q, asm_d;
  logic [W-1:0]          asm_merged;
  logic                  last_byte;
  logic                  push, pop;

  logic [W-1:0]          fifo_op_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_ip_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         count_q;

  // Assembly buffer with the byte arriving on mem_data dropped into its slot. A push uses
  // this merged value, so the last byte does not have to pass through asm_q first.
  always_comb begin
    asm_merged = asm_q;
    for (int unsigned i = 0; i < OPCODE_BYTES; i++) begin
      if (byte_idx_q == IdxW'(i)) begin
        if (BIG_ENDIAN) begin
          asm_merged[W-8-8*i +: 8] = mem.mem_data;
        end else begin
          asm_merged[8*i +: 8] = mem.mem_data;
        end
      end
    end
  end

  assign last_byte = (byte_idx_q == IdxW'(OPCODE_BYTES - 1));

  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    mem_addr_d  = mem_addr_q;
    byte_idx_d  = byte_idx_q;
    armed_d     = armed_q;
    drop_d      = drop_q;
    asm_d       = asm_q;
    push        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A redirect in IDLE costs one more IDLE cycle, so mem_addr picks up the new pointer.
        // The count check blocks only the start of an opcode. A partial opcode always has
        // room, because nothing else pushes while it is being assembled.
        if (armed_q && run && !redirect && (count_q < (PtrW+1)'(DEPTH))) begin
          state_d    = StReq;
          mem_addr_d = fetch_ptr_q + ADDR_WIDTH'(byte_idx_q);
        end
      end
      StReq: begin
        if (mem.mem_busy) state_d = StAck;
      end
      StAck: begin
        if (!mem.mem_busy) begin
          state_d = StIdle;
          drop_d  = 1'b0;
          if (!drop_q && !redirect) begin
            asm_d = asm_merged;
            if (last_byte) begin
              push        = 1'b1;
              fetch_ptr_d = fetch_ptr_q + ADDR_WIDTH'(OPCODE_BYTES);
              byte_idx_d  = '0;
            end else begin
              byte_idx_d = byte_idx_q + IdxW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      fetch_ptr_d = redirect_ip;
      byte_idx_d  = '0;
      armed_d     = 1'b1;
      // An access still waiting on the MMU must run to completion. Its byte is then
      // discarded. An access completing in this cycle is discarded above instead.
      if (state_q == StReq || (state_q == StAck && mem.mem_busy)) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      fetch_ptr_q <= '0;
      mem_addr_q  <= '0;
      byte_idx_q  <= '0;
      armed_q     <= 1'b0;
      drop_q      <= 1'b0;
      asm_q       <= '0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      mem_addr_q  <= mem_addr_d;
      byte_idx_q  <= byte_idx_d;
      armed_q     <= armed_d;
      drop_q      <= drop_d;
      asm_q       <= asm_d;
    end
  end

  // A redirect takes priority over a pop. The push is already suppressed inside the FSM.
  assign pop = consume && (count_q != '0) && !redirect;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_op_q[i] <= '0;
        fifo_ip_q[i] <= '0;
      end
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_op_q[wr_ptr_q] <= asm_merged;
        fifo_ip_q[wr_ptr_q] <= fetch_ptr_q;
        wr_ptr_q            <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + (PtrW+1)'(1);
      end else if (!push && pop) begin
        count_q <= count_q - (PtrW+1)'(1);
      end
    end
  end

  assign opcode_valid = (count_q != '0);
  assign busy         = ~opcode_valid;
  assign opcode       = fifo_op_q[rd_ptr_q];
  assign opcode_ip    = fifo_ip_q[rd_ptr_q];
  assign mem.mem_req  = (state_q != StIdle);
  assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_opcode_prefetch_queue.sv
// Directed bench for opcode_prefetch_queue.
// dut_a is the default configuration: little-endian, 4-byte opcodes, depth 4.
// dut_b is big-endian with 2-byte opcodes.
// Each DUT is served by a simple MMU model with a fixed busy latency.
module tb_opcode_prefetch_queue;

  localparam int unsigned Lat = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        redir_a, run_a, cons_a, val_a, busy_a;
  logic [31:0] rip_a, op_a, ip_a;
  logic        redir_b, run_b, cons_b, val_b, busy_b;
  logic [31:0] rip_b, ip_b;
  logic [15:0] op_b;

  opcode_prefetch_queue_if #(.ADDR_WIDTH(32)) bus_a ();
  opcode_prefetch_queue_if #(.ADDR_WIDTH(32)) bus_b ();

  opcode_prefetch_queue #(
    .OPCODE_BYTES(4), .DEPTH(4), .ADDR_WIDTH(32), .BIG_ENDIAN(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .redirect(redir_a), .redirect_ip(rip_a), .run(run_a),
    .consume(cons_a), .opcode_valid(val_a), .opcode(op_a), .opcode_ip(ip_a), .busy(busy_a),
    .mem(bus_a.master)
  );

  opcode_prefetch_queue #(
    .OPCODE_BYTES(2), .DEPTH(4), .ADDR_WIDTH(32), .BIG_ENDIAN(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .redirect(redir_b), .redirect_ip(rip_b), .run(run_b),
    .consume(cons_b), .opcode_valid(val_b), .opcode(op_b), .opcode_ip(ip_b), .busy(busy_b),
    .mem(bus_b.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory contents: the four bytes below 2^32 hold AA BB CC DD. Elsewhere a byte is its
  // address low byte plus 16 * address[11:8], so memory[i]=i below 0x100.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] hi;
    case (a)
      32'hFFFF_FFFC: return 8'hAA;
      32'hFFFF_FFFD: return 8'hBB;
      32'hFFFF_FFFE: return 8'hCC;
      32'hFFFF_FFFF: return 8'hDD;
      default: begin
        hi = {a[11:8], 4'h0};
        return a[7:0] + hi;
      end
    endcase
  endfunction

  function automatic logic [31:0] le_op(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // MMU models: accept req, stay busy for Lat cycles, then return data and wait for req to drop.
  typedef enum logic [1:0] {MIdle, MBusy, MWait} mstate_e;
  mstate_e     ms_a, ms_b;
  int unsigned cnt_a, cnt_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ms_a <= MIdle; cnt_a <= 0; bus_a.mem_busy <= 1'b0; bus_a.mem_data <= 8'h00;
    end else begin
      case (ms_a)
        MIdle: if (bus_a.mem_req) begin
          bus_a.mem_busy <= 1'b1; cnt_a <= Lat - 1; ms_a <= MBusy;
        end
        MBusy: if (cnt_a == 0) begin
          bus_a.mem_busy <= 1'b0; bus_a.mem_data <= mem_byte(bus_a.mem_addr); ms_a <= MWait;
        end else begin
          cnt_a <= cnt_a - 1;
        end
        default: if (!bus_a.mem_req) ms_a <= MIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ms_b <= MIdle; cnt_b <= 0; bus_b.mem_busy <= 1'b0; bus_b.mem_data <= 8'h00;
    end else begin
      case (ms_b)
        MIdle: if (bus_b.mem_req) begin
          bus_b.mem_busy <= 1'b1; cnt_b <= Lat - 1; ms_b <= MBusy;
        end
        MBusy: if (cnt_b == 0) begin
          bus_b.mem_busy <= 1'b0; bus_b.mem_data <= mem_byte(bus_b.mem_addr); ms_b <= MWait;
        end else begin
          cnt_b <= cnt_b - 1;
        end
        default: if (!bus_b.mem_req) ms_b <= MIdle;
      endcase
    end
  end

  // mem_addr must hold steady for as long as mem_req stays high.
  logic        prev_req  = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (reset && prev_req && bus_a.mem_req) check("addr_stable", 64'(bus_a.mem_addr), 64'(prev_addr));
    prev_req  <= bus_a.mem_req;
    prev_addr <= bus_a.mem_addr;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_val_a(input string tag);
    for (int n = 0; n < 300 && !val_a; n++) cyc();
    check(tag, 64'(val_a), 64'd1);
  endtask

  task automatic wait_val_b(input string tag);
    for (int n = 0; n < 300 && !val_b; n++) cyc();
    check(tag, 64'(val_b), 64'd1);
  endtask

  task automatic pulse_redir_a(input logic [31:0] ip);
    redir_a = 1'b1; rip_a = ip;
    cyc();
    redir_a = 1'b0;
  endtask

  logic        seen;
  logic [31:0] exp_ip;
  int          coin_n;
  logic        coin;

  initial begin
    reset = 1'b0;
    redir_a = 1'b0; rip_a = '0; run_a = 1'b1; cons_a = 1'b0;
    redir_b = 1'b0; rip_b = '0; run_b = 1'b1; cons_b = 1'b0;
    cyc(); cyc();
    check("rst_valid", 64'(val_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd1);
    check("rst_opcode", 64'(op_a), 64'd0);
    check("rst_ip", 64'(ip_a), 64'd0);
    check("rst_req", 64'(bus_a.mem_req), 64'd0);
    check("rst_addr", 64'(bus_a.mem_addr), 64'd0);

    // Out of reset with no redirect: nothing should be fetched.
    reset = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      cyc();
      seen = seen | bus_a.mem_req | val_a | bus_b.mem_req | val_b;
    end
    check("idle_no_fetch", 64'(seen), 64'd0);

    // Big-endian, 2-byte opcodes from address 6.
    redir_b = 1'b1; rip_b = 32'd6;
    cyc();
    redir_b = 1'b0;
    wait_val_b("be_valid0");
    check("be_op0", 64'(op_b), 64'h0607);
    check("be_ip0", 64'(ip_b), 64'd6);
    cons_b = 1'b1;
    cyc();
    cons_b = 1'b0;
    wait_val_b("be_valid1");
    check("be_op1", 64'(op_b), 64'h0809);
    check("be_ip1", 64'(ip_b), 64'd8);

    // Little-endian fill with no consume: the queue fills, then the engine parks.
    pulse_redir_a(32'd0);
    repeat (250) cyc();
    check("full_valid", 64'(val_a), 64'd1);
    seen = 1'b0;
    repeat (10) begin
      cyc();
      seen = seen | bus_a.mem_req;
    end
    check("full_no_req", 64'(seen), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check("fill_op", 64'(op_a), 64'(le_op(32'(4 * k))));
      check("fill_ip", 64'(ip_a), 64'(4 * k));
      cons_a = 1'b1;
      cyc();
    end
    cons_a = 1'b0;
    check("drained", 64'(val_a), 64'd0);

    // Pop exactly on the edge that captures the last byte, so push and pop coincide.
    exp_ip = 32'd16;
    coin_n = 0;
    for (int c = 0; c < 300; c++) begin
      coin = (ms_a == MWait) && bus_a.mem_req && (bus_a.mem_addr[1:0] == 2'd3);
      cons_a = val_a && coin;
      if (cons_a) begin
        coin_n++;
        check("drain_ip", 64'(ip_a), 64'(exp_ip));
        check("drain_op", 64'(op_a), 64'(le_op(exp_ip)));
        exp_ip = exp_ip + 32'd4;
      end
      cyc();
    end
    cons_a = 1'b0;
    check("coincide_seen", 64'(coin_n > 0), 64'd1);
    check("after_coincide_ip", 64'(ip_a), 64'(exp_ip));

    // Redirect and consume in the same cycle, with at least two entries queued.
    repeat (80) cyc();
    check("pre_rc_valid", 64'(val_a), 64'd1);
    redir_a = 1'b1; rip_a = 32'h200; cons_a = 1'b1;
    cyc();
    redir_a = 1'b0; cons_a = 1'b0;
    check("redir_cons_valid", 64'(val_a), 64'd0);
    check("redir_cons_busy", 64'(busy_a), 64'd1);

    // Redirect while byte 2 of address 0 is still being acknowledged.
    pulse_redir_a(32'd0);
    for (int n = 0; n < 300 && !(bus_a.mem_req && bus_a.mem_busy && bus_a.mem_addr == 32'd2); n++)
      cyc();
    check("ack_b2_seen", 64'(bus_a.mem_addr), 64'd2);
    cyc();
    pulse_redir_a(32'h100);
    for (int n = 0; n < 50 && bus_a.mem_req; n++) cyc();
    check("drop_req_low", 64'(bus_a.mem_req), 64'd0);
    for (int n = 0; n < 50 && !bus_a.mem_req; n++) cyc();
    check("drop_next_addr", 64'(bus_a.mem_addr), 64'h100);
    check("drop_no_push", 64'(val_a), 64'd0);
    wait_val_a("drop_valid");
    check("drop_op", 64'(op_a), 64'h1312_1110);
    check("drop_ip", 64'(ip_a), 64'h100);

    // Address wrap, with run dropped partway through the opcode.
    pulse_redir_a(32'hFFFF_FFFC);
    for (int n = 0; n < 300 && !(bus_a.mem_req && bus_a.mem_addr == 32'hFFFF_FFFD); n++) cyc();
    check("wrap_b1_seen", 64'(bus_a.mem_addr), 64'hFFFF_FFFD);
    run_a = 1'b0;
    repeat (40) cyc();
    check("paused_req", 64'(bus_a.mem_req), 64'd0);
    check("paused_addr", 64'(bus_a.mem_addr), 64'hFFFF_FFFD);
    check("paused_valid", 64'(val_a), 64'd0);
    run_a = 1'b1;
    wait_val_a("wrap_valid");
    check("wrap_op", 64'(op_a), 64'hDDCC_BBAA);
    check("wrap_ip", 64'(ip_a), 64'hFFFF_FFFC);
    for (int n = 0; n < 50 && !bus_a.mem_req; n++) cyc();
    check("wrap_next_addr", 64'(bus_a.mem_addr), 64'd0);
    cons_a = 1'b1;
    cyc();
    cons_a = 1'b0;
    wait_val_a("wrap_valid1");
    check("wrap_op1", 64'(op_a), 64'h0302_0100);
    check("wrap_ip1", 64'(ip_a), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
